// File: rtl/util_axis_uart_pkg.sv
// Shared types and helpers for the util_axis_uart family of blocks.
package util_axis_uart_pkg;

    localparam int DEFAULT_NUM_PORTS = 4;
    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_BURST_MAX = 16;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Ceiling log2; clog2(1) is 0, callers clamp to a minimum width where needed.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/util_rr_pick.sv
// Combinational round-robin picker: first asserted request searching upward
// from (last + 1) mod NUM_PORTS. Shared by the TX arbiter and future schedulers.
module util_rr_pick
    import util_axis_uart_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int ID_W      = clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_W-1:0]      last,
    output logic [ID_W-1:0]      pick_id,
    output logic                 pick_valid
);

    // Scan the ports in rotated order and keep the first hit.
    always_comb begin : pick_search
        logic [ID_W-1:0] cand;
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise the tool infers a latch.
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = ID_W'((int'(last) + i) % NUM_PORTS);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

endmodule

// File: rtl/util_axis_uart_arbiter.sv
// Round-robin burst arbiter sharing one UART transmit AXI-Stream slave between
// NUM_PORTS byte-stream requesters. A grant lasts until the requester's tlast
// beat or BURST_MAX beats (BURST_MAX = 0 means tlast only).
module util_axis_uart_arbiter
    import util_axis_uart_pkg::*;
#(
    parameter int  NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int  DATA_BITS = DEFAULT_DATA_BITS,
    parameter int  BURST_MAX = DEFAULT_BURST_MAX,
    localparam int ID_W      = clog2(NUM_PORTS)
) (
    input  logic                           aclk,
    input  logic                           arst,
    input  logic [NUM_PORTS*DATA_BITS-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]           s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]           s_axis_tlast,
    output logic [NUM_PORTS-1:0]           s_axis_tready,
    output logic [DATA_BITS-1:0]           m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           grant_valid,
    output logic [ID_W-1:0]                grant_id
);

    localparam int CNT_RAW = clog2(BURST_MAX + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam bit HAS_LIMIT = (BURST_MAX != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((BURST_MAX == 0) ? 0 : BURST_MAX - 1);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [ID_W-1:0]  pick_id;
    logic             pick_valid;
    logic             beat;
    logic             release_grant;

    util_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .ID_W      (ID_W)
    ) u_pick (
        .req        (s_axis_tvalid),
        .last       (last_q),
        .pick_id    (pick_id),
        .pick_valid (pick_valid)
    );

    assign grant_valid = (state_q == XFER);
    assign grant_id    = grant_id_q;

    // Zero-cycle passthrough from the granted requester to the UART slave.
    always_comb begin
        m_axis_tdata  = s_axis_tdata[int'(grant_id_q) * DATA_BITS +: DATA_BITS];
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        if (state_q == XFER) begin
            m_axis_tvalid             = s_axis_tvalid[grant_id_q];
            s_axis_tready[grant_id_q] = m_axis_tready;
        end
    end

    assign beat          = m_axis_tvalid && m_axis_tready;
    assign release_grant = beat && (s_axis_tlast[grant_id_q] ||
                                    (HAS_LIMIT && (beat_cnt_q == CNT_LAST)));

    // Next-state logic: arbitrate in IDLE, count beats and release in XFER.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = XFER;
                    grant_id_d = pick_id;
                    last_d     = pick_id;
                    beat_cnt_d = '0;
                end
            end
            XFER: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // A tvalid gap never releases; only tlast or the burst limit does.
                if (release_grant) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; reset wins over an in-flight beat.
    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block evaluation order.
        if (arst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            last_q     <= ID_W'(NUM_PORTS - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_util_axis_uart_arbiter.sv
// Scoreboard bench for util_axis_uart_arbiter: per-port AXIS sources, an
// expected-beat queue filled by the directed tests, and a monitor that checks
// every beat the arbiter forwards.
module tb_util_axis_uart_arbiter;

    localparam int NUM_PORTS = 4;
    localparam int DATA_BITS = 8;
    localparam int BURST_MAX = 4;
    localparam int ID_W      = 2;

    logic                           aclk = 1'b0;
    logic                           arst;
    logic [NUM_PORTS*DATA_BITS-1:0] s_axis_tdata;
    logic [NUM_PORTS-1:0]           s_axis_tvalid;
    logic [NUM_PORTS-1:0]           s_axis_tlast;
    logic [NUM_PORTS-1:0]           s_axis_tready;
    logic [DATA_BITS-1:0]           m_axis_tdata;
    logic                           m_axis_tvalid;
    logic                           m_axis_tready;
    logic                           grant_valid;
    logic [ID_W-1:0]                grant_id;

    typedef struct {
        logic [DATA_BITS-1:0] data;
        logic                 last;
    } beat_t;

    typedef struct {
        int                   port;
        logic [DATA_BITS-1:0] data;
    } exp_t;

    beat_t src_q [NUM_PORTS][$];
    exp_t  exp_q [$];
    bit    gap   [NUM_PORTS];
    bit    hs    [NUM_PORTS];

    int n_cmp = 0;
    int n_err = 0;

    util_axis_uart_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .DATA_BITS (DATA_BITS),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .aclk          (aclk),
        .arst          (arst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic bit srcs_empty();
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (src_q[p].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic push_src(input int p, input logic [7:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        src_q[p].push_back(b);
    endtask

    task automatic expect_beat(input int p, input logic [7:0] data);
        exp_t e;
        e.port = p;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for the first cycle with a grant; returns at its negedge.
    task automatic wait_grant(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            if (grant_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    // Runs until all sources drain and the grant drops; counts granted cycles
    // and IDLE bubbles seen after the first grant.
    task automatic wait_done(input string name, output int gv, output int gaps);
        bit done, seen;
        done = 1'b0;
        seen = 1'b0;
        gv   = 0;
        gaps = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge aclk);
            if (grant_valid) begin
                gv++;
                seen = 1'b1;
            end else if (srcs_empty()) begin
                done = 1'b1;
                break;
            end else if (seen) begin
                gaps++;
            end
        end
        check({name, "_done"}, done, 1);
        check({name, "_sb_drained"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #2 arst = 1'b1;
        repeat (2) @(posedge aclk);
        #2 arst = 1'b0;
    endtask

    // AXIS sources: sample handshakes mid-cycle, then pop and drive after the edge.
    initial begin : sources
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        for (int p = 0; p < NUM_PORTS; p++) gap[p] = 1'b0;
        forever begin
            @(negedge aclk);
            for (int p = 0; p < NUM_PORTS; p++) begin
                hs[p] = s_axis_tvalid[p] && s_axis_tready[p];
            end
            @(posedge aclk);
            #1;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (hs[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
                if (src_q[p].size() != 0 && !gap[p]) begin
                    s_axis_tvalid[p]                         = 1'b1;
                    s_axis_tdata[p*DATA_BITS +: DATA_BITS]   = src_q[p][0].data;
                    s_axis_tlast[p]                          = src_q[p][0].last;
                end else begin
                    s_axis_tvalid[p]                         = 1'b0;
                    s_axis_tdata[p*DATA_BITS +: DATA_BITS]   = '0;
                    s_axis_tlast[p]                          = 1'b0;
                end
            end
        end
    end

    // Monitor: every forwarded beat must match the head of the expected queue.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge aclk);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got port %0d data 0x%0h, expected no beat", grant_id, m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_port", grant_id, e.port);
                    check("beat_data", m_axis_tdata, e.data);
                    check("beat_ready_onehot", s_axis_tready, 32'd1 << e.port);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int         gv, gaps;
        logic [4:0] pat;

        arst          = 1'b1;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #2 arst = 1'b0;

        @(negedge aclk);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_s_tready", s_axis_tready, 0);

        // Single port 1 burst of three bytes.
        push_src(1, 8'h41, 0); push_src(1, 8'h42, 0); push_src(1, 8'h43, 1);
        expect_beat(1, 8'h41); expect_beat(1, 8'h42); expect_beat(1, 8'h43);
        @(negedge aclk);
        check("t1_idle_while_request_seen", grant_valid, 0);
        @(negedge aclk);
        check("t1_grant_valid", grant_valid, 1);
        check("t1_grant_id", grant_id, 1);
        wait_done("t1", gv, gaps);
        check("t1_remaining_grant_cycles", gv, 2);
        check("t1_gaps", gaps, 0);

        // Fairness after reset: all ports, single-beat bursts, order 0,1,2,3,0,1,2,3.
        do_reset();
        @(negedge aclk);
        check("t2_rst_grant_id", grant_id, 0);
        check("t2_rst_grant_valid", grant_valid, 0);
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                push_src(p, 8'(8'h80 + p * 16 + k), 1);
                expect_beat(p, 8'(8'h80 + p * 16 + k));
            end
        end
        wait_done("t2", gv, gaps);
        check("t2_grant_cycles", gv, 8);
        check("t2_idle_bubbles", gaps, 7);

        // Burst limit: port 2 streams 8 beats with no tlast, port 0 joins.
        for (int k = 0; k < 8; k++) push_src(2, 8'(8'hA0 + k), 0);
        @(negedge aclk);
        push_src(0, 8'hB0, 0); push_src(0, 8'hB1, 1);
        for (int k = 0; k < 4; k++) expect_beat(2, 8'(8'hA0 + k));
        expect_beat(0, 8'hB0); expect_beat(0, 8'hB1);
        for (int k = 4; k < 8; k++) expect_beat(2, 8'(8'hA0 + k));
        wait_done("t3", gv, gaps);
        check("t3_grant_cycles", gv, 10);
        check("t3_idle_bubbles", gaps, 2);

        // tlast on the limit beat releases once; next burst starts a fresh count.
        for (int k = 0; k < 4; k++) push_src(1, 8'(8'hC0 + k), (k == 3));
        push_src(1, 8'hC4, 1);
        push_src(3, 8'hD0, 1);
        expect_beat(3, 8'hD0);
        for (int k = 0; k < 5; k++) expect_beat(1, 8'(8'hC0 + k));
        wait_done("t4", gv, gaps);
        check("t4_grant_cycles", gv, 6);
        check("t4_idle_bubbles", gaps, 2);

        // Backpressure on port 3: tready 1,0,0,1 then 1 for the final beat.
        m_axis_tready = 1'b0;
        push_src(3, 8'hE0, 0); push_src(3, 8'hE1, 0); push_src(3, 8'hE2, 1);
        expect_beat(3, 8'hE0); expect_beat(3, 8'hE1); expect_beat(3, 8'hE2);
        wait_grant("t5_grant_seen");
        check("t5_stalled_s_tready", s_axis_tready, 0);
        check("t5_stalled_m_tvalid", m_axis_tvalid, 1);
        pat = 5'b11001;
        for (int k = 0; k < 5; k++) begin
            @(posedge aclk);
            #2 m_axis_tready = pat[k];
            @(negedge aclk);
            check("t5_s_tready_follows", s_axis_tready, pat[k] ? 32'h8 : 32'h0);
        end
        m_axis_tready = 1'b1;
        wait_done("t5", gv, gaps);
        check("t5_released_after_last", gv, 0);

        // Gap hold: port 0 drops tvalid for 5 cycles while port 1 waits.
        push_src(0, 8'hF0, 0); push_src(0, 8'hF1, 0); push_src(0, 8'hF2, 1);
        push_src(1, 8'h60, 1);
        expect_beat(0, 8'hF0); expect_beat(0, 8'hF1); expect_beat(0, 8'hF2);
        expect_beat(1, 8'h60);
        wait_grant("t6_grant_seen");
        check("t6_first_grant_id", grant_id, 0);
        gap[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check("t6_hold_valid", grant_valid, 1);
            check("t6_hold_id", grant_id, 0);
        end
        gap[0] = 1'b0;
        wait_done("t6", gv, gaps);
        check("t6_grant_cycles", gv, 3);
        check("t6_idle_bubbles", gaps, 1);

        // Reset mid-burst on port 1; port 0 requesting must win afterwards.
        push_src(1, 8'h70, 0); push_src(1, 8'h71, 0); push_src(1, 8'h72, 1);
        expect_beat(1, 8'h70); expect_beat(1, 8'h71);
        expect_beat(0, 8'h30);
        expect_beat(1, 8'h72);
        wait_grant("t7_grant_seen");
        push_src(0, 8'h30, 1);
        @(posedge aclk);
        #2 arst = 1'b1;
        @(posedge aclk);
        #2 arst = 1'b0;
        @(negedge aclk);
        check("t7_rst_grant_valid", grant_valid, 0);
        check("t7_rst_m_tvalid", m_axis_tvalid, 0);
        check("t7_rst_s_tready", s_axis_tready, 0);
        wait_done("t7", gv, gaps);
        check("t7_grant_cycles", gv, 2);
        check("t7_idle_bubbles", gaps, 1);

        repeat (3) @(negedge aclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
